// File: rtl/pkt_loader.sv
// pkt_loader
//   Packs an inbound byte stream into little-endian 32-bit words, writes each
//   completed (or final partial) word to memory at base + 4*word_index, then
//   raises start_o toward an executor and holds it until exec_done_i.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   rx_valid_i/rx_data_i/rx_last_i/rx_ready_o : inbound byte handshake
//   base_addr_i       : packet buffer byte address, sampled on the first byte
//   mem_ce_o/mem_we_o/mem_addr_o/mem_width_o/mem_data_o : registered write port
//   start_o/start_addr_o/exec_done_i : executor handshake
//   pkt_len_o         : bytes stored for the current packet (saturating)
//   overflow_o        : packet ran past MAX_BYTES
module pkt_loader #(
  parameter int MAX_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_last_i,
  output logic        rx_ready_o,
  input  logic [31:0] base_addr_i,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_width_o,
  output logic [31:0] mem_data_o,
  output logic        start_o,
  output logic [31:0] start_addr_o,
  input  logic        exec_done_i,
  output logic [15:0] pkt_len_o,
  output logic        overflow_o
);

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, START, WAIT_DONE} state_t;

  localparam logic [16:0] MAX_L = 17'(MAX_BYTES);

  state_t      state, state_nxt;
  logic [31:0] asm_word;
  logic        accept;
  logic        in_range;
  logic        emit_word;
  logic [15:0] idx;
  logic [31:0] word_base;
  logic [31:0] byte_off;
  logic [31:0] packed_word;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign rx_ready_o = !rst && ((state == IDLE) || (state == FILL));
  assign accept     = rx_valid_i && rx_ready_o;
  assign start_o    = (state == START) || (state == WAIT_DONE);

  // In IDLE the incoming byte is byte 0 of a fresh packet: the stale length,
  // assembly word and latched base must not leak into it.
  always_comb begin
    idx         = (state == IDLE) ? 16'd0 : pkt_len_o;
    word_base   = (state == IDLE) ? base_addr_i : start_addr_o;
    in_range    = ({1'b0, idx} < MAX_L);
    packed_word = put_byte((state == IDLE) ? 32'd0 : asm_word, idx[1:0], rx_data_i);
    byte_off    = {16'd0, idx[15:2], 2'b00};
    // A final partial word is written on the same edge as its last byte, so
    // the write is visible during the single FLUSH cycle.
    emit_word   = in_range && ((idx[1:0] == 2'd3) || rx_last_i);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FILL: if (accept) state_nxt = rx_last_i ? FLUSH : FILL;
      FLUSH:      state_nxt = START;
      START:      state_nxt = exec_done_i ? IDLE : WAIT_DONE;
      WAIT_DONE:  state_nxt = exec_done_i ? IDLE : WAIT_DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pkt_len_o    <= '0;
      overflow_o   <= 1'b0;
      start_addr_o <= '0;
      asm_word     <= '0;
      mem_ce_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_width_o  <= '0;
      mem_data_o   <= '0;
    end else begin
      state       <= state_nxt;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      mem_data_o  <= '0;
      if (accept) begin
        if (state == IDLE) begin
          start_addr_o <= base_addr_i;
          overflow_o   <= 1'b0;
        end
        if (in_range) begin
          pkt_len_o <= idx + 16'd1;
          // Once a word is handed to the write stage the assembly register is
          // free again, so unused lanes of the next partial word read as zero.
          asm_word  <= emit_word ? 32'd0 : packed_word;
          if (emit_word) begin
            mem_ce_o    <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_width_o <= 4'd4;
            mem_addr_o  <= word_base + byte_off;
            mem_data_o  <= packed_word;
          end
        end else begin
          overflow_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_loader.sv
// Scoreboard bench for pkt_loader: two instances (default capacity and an
// 8-byte capacity) share stimulus; a packet-level model pushes the expected
// memory writes, and negedge monitors pop and compare them.
module tb_pkt_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rx_valid_i, rx_last_i, exec_done_i;
  logic [7:0]  rx_data_i;
  logic [31:0] base_addr_i;

  logic        rdy_a, ce_a, we_a, start_a, ovf_a;
  logic [31:0] addr_a, data_a, saddr_a;
  logic [3:0]  width_a;
  logic [15:0] len_a;
  logic        rdy_b, ce_b, we_b, start_b, ovf_b;
  logic [31:0] addr_b, data_b, saddr_b;
  logic [3:0]  width_b;
  logic [15:0] len_b;

  pkt_loader dut_a (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_last_i(rx_last_i), .rx_ready_o(rdy_a), .base_addr_i(base_addr_i),
    .mem_ce_o(ce_a), .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_width_o(width_a),
    .mem_data_o(data_a), .start_o(start_a), .start_addr_o(saddr_a),
    .exec_done_i(exec_done_i), .pkt_len_o(len_a), .overflow_o(ovf_a)
  );

  pkt_loader #(.MAX_BYTES(8)) dut_b (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_last_i(rx_last_i), .rx_ready_o(rdy_b), .base_addr_i(base_addr_i),
    .mem_ce_o(ce_b), .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_width_o(width_b),
    .mem_data_o(data_b), .start_o(start_b), .start_addr_o(saddr_b),
    .exec_done_i(exec_done_i), .pkt_len_o(len_b), .overflow_o(ovf_b)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         qa[$];
  wr_t         qb[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  pkt_bytes[64];
  int          exp_len[2];
  bit          exp_ovf[2];
  logic [31:0] cur_base;
  wr_t         got_a, got_b;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitors: every write presented must be the next expected one; an idle
  // bus must be all zero.
  always @(negedge clk) begin
    if (ce_a === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_write: got addr 0x%08h data 0x%08h expected none", addr_a, data_a);
      end else begin
        got_a = qa.pop_front();
        check("a_wr_addr", addr_a, got_a.addr);
        check("a_wr_data", data_a, got_a.data);
        check("a_wr_ctl", {27'd0, we_a, width_a}, {27'd0, 1'b1, 4'd4});
      end
    end else begin
      check("a_idle_bus", addr_a | data_a | {27'd0, we_a, width_a}, 32'd0);
    end
    if (ce_b === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_write: got addr 0x%08h data 0x%08h expected none", addr_b, data_b);
      end else begin
        got_b = qb.pop_front();
        check("b_wr_addr", addr_b, got_b.addr);
        check("b_wr_data", data_b, got_b.data);
        check("b_wr_ctl", {27'd0, we_b, width_b}, {27'd0, 1'b1, 4'd4});
      end
    end else begin
      check("b_idle_bus", addr_b | data_b | {27'd0, we_b, width_b}, 32'd0);
    end
  end

  // Packet-level reference: the first min(n, capacity) bytes land in memory
  // as little-endian words; an aborted packet only keeps its full words.
  task automatic model_pkt(input logic [31:0] base, input int n, input bit aborted);
    int lim, stored, nw;
    logic [31:0] word;
    wr_t e;
    for (int m = 0; m < 2; m++) begin
      lim    = (m == 0) ? 2048 : 8;
      stored = (n < lim) ? n : lim;
      nw     = aborted ? stored / 4 : (stored + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        word = 32'd0;
        for (int b = 0; b < 4; b++)
          if (w * 4 + b < stored) word = word | (32'(pkt_bytes[w * 4 + b]) << (8 * b));
        e.addr = base + 32'(4 * w);
        e.data = word;
        if (m == 0) qa.push_back(e); else qb.push_back(e);
      end
      exp_len[m] = stored;
      exp_ovf[m] = (n > lim);
    end
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n, input bit gaps, input bit with_last);
    int k;
    cur_base = base;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        rx_valid_i = 1'b0;
        k = $urandom_range(0, 2);
        repeat (k) begin @(posedge clk); #1; end
      end
      rx_valid_i  = 1'b1;
      rx_data_i   = pkt_bytes[i];
      rx_last_i   = with_last && (i == n - 1);
      base_addr_i = (i == 0) ? base : $urandom;
      check("a_rx_ready", {31'd0, rdy_a}, 32'd1);
      check("b_rx_ready", {31'd0, rdy_b}, 32'd1);
      @(posedge clk); #1;
      if (i == 0) begin
        check("a_first_saddr", saddr_a, base);
        check("b_first_saddr", saddr_b, base);
        check("a_first_len", {16'd0, len_a}, 32'd1);
        check("b_first_len", {16'd0, len_b}, 32'd1);
        check("a_first_ovf", {31'd0, ovf_a}, 32'd0);
        check("b_first_ovf", {31'd0, ovf_b}, 32'd0);
      end
    end
    rx_valid_i  = 1'b0;
    rx_last_i   = 1'b0;
    base_addr_i = $urandom;
  endtask

  // Called in the FLUSH cycle right after the last byte was accepted.
  task automatic finish_pkt();
    check("a_flush_start", {31'd0, start_a}, 32'd0);
    check("a_flush_ready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk); #1;
    check("a_start", {31'd0, start_a}, 32'd1);
    check("b_start", {31'd0, start_b}, 32'd1);
    check("a_start_addr", saddr_a, cur_base);
    check("b_start_addr", saddr_b, cur_base);
    check("a_pkt_len", {16'd0, len_a}, 32'(exp_len[0]));
    check("b_pkt_len", {16'd0, len_b}, 32'(exp_len[1]));
    check("a_overflow", {31'd0, ovf_a}, {31'd0, exp_ovf[0]});
    check("b_overflow", {31'd0, ovf_b}, {31'd0, exp_ovf[1]});
    check("a_start_ready", {31'd0, rdy_a}, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("a_start_held", {31'd0, start_a}, 32'd1);
    exec_done_i = 1'b1;
    @(posedge clk); #1;
    exec_done_i = 1'b0;
    check("a_done_start", {31'd0, start_a}, 32'd0);
    check("b_done_start", {31'd0, start_b}, 32'd0);
    check("a_done_ready", {31'd0, rdy_a}, 32'd1);
    check("a_pending_writes", 32'(qa.size()), 32'd0);
    check("b_pending_writes", 32'(qb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid_i = 1'b0;
    #1;
    check("a_ready_in_reset", {31'd0, rdy_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("a_rst_start", {31'd0, start_a}, 32'd0);
    check("b_rst_start", {31'd0, start_b}, 32'd0);
    check("a_rst_len", {16'd0, len_a}, 32'd0);
    check("a_rst_ovf", {31'd0, ovf_a}, 32'd0);
    check("a_rst_saddr", saddr_a, 32'd0);
    check("a_rst_ce", {31'd0, ce_a}, 32'd0);
    check("a_rst_ready", {31'd0, rdy_a}, 32'd1);
    check("a_rst_pending", 32'(qa.size()), 32'd0);
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++) pkt_bytes[i] = 8'($urandom);
  endtask

  initial begin
    int n;
    logic [31:0] b;
    rst = 1'b1; rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_data_i = 8'd0;
    base_addr_i = 32'd0; exec_done_i = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Eight bytes back-to-back.
    for (int i = 0; i < 8; i++) pkt_bytes[i] = 8'(8'h11 * (i + 1));
    model_pkt(32'd64, 8, 1'b0);
    send_pkt(32'd64, 8, 1'b0, 1'b1);
    finish_pkt();

    // Three-byte packet: single partial write.
    pkt_bytes[0] = 8'hAA; pkt_bytes[1] = 8'hBB; pkt_bytes[2] = 8'hCC;
    model_pkt(32'd128, 3, 1'b0);
    send_pkt(32'd128, 3, 1'b0, 1'b1);
    finish_pkt();

    // Ten bytes: overflows the 8-byte instance.
    rand_bytes(10);
    model_pkt(32'd256, 10, 1'b0);
    send_pkt(32'd256, 10, 1'b0, 1'b1);
    finish_pkt();

    // Reset after six bytes, then a 4-byte packet at base 0.
    rand_bytes(6);
    model_pkt(32'd512, 6, 1'b1);
    send_pkt(32'd512, 6, 1'b0, 1'b0);
    do_reset();
    rand_bytes(4);
    model_pkt(32'd0, 4, 1'b0);
    send_pkt(32'd0, 4, 1'b0, 1'b1);
    finish_pkt();

    // Reset while waiting for the executor.
    rand_bytes(5);
    model_pkt(32'd1024, 5, 1'b0);
    send_pkt(32'd1024, 5, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("a_wait_start", {31'd0, start_a}, 32'd1);
    do_reset();

    // Sixteen bytes back-to-back, then the same bytes with idle gaps.
    rand_bytes(16);
    model_pkt(32'h0000_2000, 16, 1'b0);
    send_pkt(32'h0000_2000, 16, 1'b0, 1'b1);
    finish_pkt();
    model_pkt(32'h0000_2000, 16, 1'b0);
    send_pkt(32'h0000_2000, 16, 1'b1, 1'b1);
    finish_pkt();

    // Address wrap past 2^32.
    rand_bytes(16);
    model_pkt(32'hFFFF_FFF4, 16, 1'b0);
    send_pkt(32'hFFFF_FFF4, 16, 1'b1, 1'b1);
    finish_pkt();

    // Random packets.
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 20);
      b = $urandom;
      rand_bytes(n);
      model_pkt(b, n, 1'b0);
      send_pkt(b, n, 1'($urandom_range(0, 1)), 1'b1);
      finish_pkt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
